// File: rtl/neuron_writeback_pkg.sv
// Shared nn types for the neuron writeback path: result/entry structs,
// saturation limits, FSM states and the 24-bit saturation helper.
package neuron_writeback_pkg;

  localparam int unsigned SUM_W   = 48;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned NW_W    = 11;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 48'sd8388607;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -48'sd8388608;

  // Calculator result as presented on the input handshake
  typedef struct packed {
    logic [SUM_W-1:0]   sum;
    logic [SHIFT_W-1:0] postshift;
    logic [ADDR_W-1:0]  oloc;
    logic               last;
  } calc_res_t;

  // Post-processed FIFO entry
  typedef struct packed {
    logic [ADDR_W-1:0] oloc;
    logic              last;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_REQ   = 2'd1,
    WB_WRITE = 2'd2
  } wb_state_e;

  // Clamp a signed 48-bit value into the signed 24-bit range
  function automatic logic [DATA_W-1:0] sat24(input logic signed [SUM_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
    else                  r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/neuron_writeback_if.sv
// Result-input handshake plus data-memory write port of the writeback block.
interface neuron_writeback_if;
  import neuron_writeback_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   in_sum;
  logic [SHIFT_W-1:0] in_postshift;
  logic [ADDR_W-1:0]  in_oloc;
  logic               in_last;

  logic               wr_req;
  logic               wr_gnt;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  // Writeback block side
  modport slave (
    input  in_valid, in_sum, in_postshift, in_oloc, in_last, wr_gnt,
    output in_ready, wr_req, wr_en, wr_addr, wr_data
  );

  // Calculator / arbiter / memory side
  modport master (
    output in_valid, in_sum, in_postshift, in_oloc, in_last, wr_gnt,
    input  in_ready, wr_req, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/neuron_writeback_wb_fifo.sv
// Result FIFO: flop array with wrapping pointers and a registered full flag.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  // Pointer/occupancy update; clear wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
    full_d = (count_d == OCC_W'(DEPTH));
  end

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/neuron_writeback.sv
// Neuron writeback: shift/ReLU/saturate results, queue them, and write them
// to data memory through a request/grant arbiter port.
module neuron_writeback
  import neuron_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              relu_en,
  input  logic              clear,
  neuron_writeback_if.slave bus,
  output logic [NW_W-1:0]   neurons_written,
  output logic              done
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  calc_res_t               res_c;
  logic signed [SUM_W-1:0] shifted_c;
  logic signed [SUM_W-1:0] relu_c;
  wb_entry_t               push_entry_c;
  wb_entry_t               head_c;

  logic             push_c, pop_c;
  logic             fifo_full, fifo_empty;
  logic [OCC_W-1:0] fifo_count;

  wb_state_e         state_q, state_d;
  logic              wr_req_q, wr_req_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_last_q, wr_last_d;
  logic [NW_W-1:0]   nw_q, nw_d;
  logic              done_q, done_d;

  // Post-processing of the incoming result: floor shift, optional ReLU, clamp
  always_comb begin
    res_c = '{sum: bus.in_sum, postshift: bus.in_postshift,
              oloc: bus.in_oloc, last: bus.in_last};
    shifted_c = $signed(res_c.sum) >>> res_c.postshift;
    relu_c    = (relu_en && shifted_c[SUM_W-1]) ? '0 : shifted_c;
    push_entry_c = '{oloc: res_c.oloc, last: res_c.last, data: sat24(relu_c)};
  end

  assign push_c = bus.in_valid && !fifo_full;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (push_entry_c),
    .rdata (head_c),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write FSM next state and registered-output precompute
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      WB_IDLE:  if (!fifo_empty) state_d = WB_REQ;
      WB_REQ:   if (bus.wr_gnt)  state_d = WB_WRITE;
      WB_WRITE: begin
        pop_c   = 1'b1;
        state_d = (fifo_count > OCC_W'(1) || push_c) ? WB_REQ : WB_IDLE;
      end
      default:  state_d = WB_IDLE;
    endcase
    if (clear) state_d = WB_IDLE;

    wr_req_d  = (state_d == WB_REQ);
    wr_en_d   = (state_d == WB_WRITE);
    wr_addr_d = wr_en_d ? head_c.oloc : '0;
    wr_data_d = wr_en_d ? head_c.data : '0;
    wr_last_d = wr_en_d && head_c.last;
    done_d    = wr_en_q && wr_last_q && !clear;
    nw_d      = clear ? '0 : nw_q + NW_W'(wr_en_q);
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WB_IDLE;
      wr_req_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_last_q <= 1'b0;
      nw_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_req_q  <= wr_req_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_last_q <= wr_last_d;
      nw_q      <= nw_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.wr_req      = wr_req_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign neurons_written = nw_q;
  assign done            = done_q;

endmodule

// File: tb/tb_neuron_writeback.sv
// Self-checking bench for neuron_writeback: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_neuron_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        relu_en = 1'b0;
  logic        clear = 1'b0;
  logic [10:0] nw;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_writeback_if bus ();

  neuron_writeback #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .relu_en         (relu_en),
    .clear           (clear),
    .bus             (bus),
    .neurons_written (nw),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: floor(sum / 2^sh), optional ReLU, clamp to signed 24 bits
  function automatic logic [23:0] ref_data(input logic [47:0] sum, input logic [4:0] sh, input logic relu);
    longint s, d, q;
    s = longint'($signed(sum));
    d = longint'(1) << sh;
    q = s / d;
    if (s < 0 && (q * d) != s) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 8388607) q = 8388607;
    else if (q < -8388608) q = -8388608;
    return q[23:0];
  endfunction

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
    logic        last;
  } exp_t;

  exp_t        mq[$];
  logic [10:0] m_nw = '0;
  logic        m_done = 1'b0;

  // Model update at each clock edge (pre-edge values are sampled)
  always @(posedge clk or negedge reset) begin : model
    int   occ;
    exp_t e;
    occ = mq.size();
    if (!reset || clear) begin
      mq.delete();
      m_nw   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.wr_en) begin
        m_nw = m_nw + 11'd1;
        if (occ > 0) begin
          m_done = mq[0].last;
          void'(mq.pop_front());
        end
      end
      if (bus.in_valid && occ < DEPTH) begin
        e.addr = bus.in_oloc;
        e.data = ref_data(bus.in_sum, bus.in_postshift, relu_en);
        e.last = bus.in_last;
        mq.push_back(e);
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_en) begin
        if (mq.size() == 0) check_eq("wr_unexpected", 64'(bus.wr_en), 64'(0));
        else begin
          check_eq("wr_addr", 64'(bus.wr_addr), 64'(mq[0].addr));
          check_eq("wr_data", 64'(bus.wr_data), 64'(mq[0].data));
        end
      end else begin
        check_eq("wr_idle_zero", 64'({bus.wr_addr, bus.wr_data}), 64'(0));
      end
      check_eq("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
      check_eq("done", 64'(done), 64'(m_done));
      check_eq("nw", 64'(nw), 64'(m_nw));
    end
  end

  task automatic set_in(input logic [47:0] s, input logic [4:0] sh, input logic [15:0] a,
                        input logic l, input logic r);
    bus.in_valid     = 1'b1;
    bus.in_sum       = s;
    bus.in_postshift = sh;
    bus.in_oloc      = a;
    bus.in_last      = l;
    relu_en          = r;
  endtask

  // Offer one result for a single cycle (fifo assumed to have room)
  task automatic send1(input logic [47:0] s, input logic [4:0] sh, input logic [15:0] a,
                       input logic l, input logic r);
    @(negedge clk);
    set_in(s, sh, a, l, r);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag, input logic [15:0] a, input logic [23:0] d);
    for (int i = 0; i < 20; i++) begin
      if (bus.wr_en) break;
      @(negedge clk);
    end
    check_eq({tag, "_seen"}, 64'(bus.wr_en), 64'(1));
    check_eq({tag, "_addr"}, 64'(bus.wr_addr), 64'(a));
    check_eq({tag, "_data"}, 64'(bus.wr_data), 64'(d));
    @(negedge clk);
  endtask

  function automatic logic [47:0] rand_sum();
    logic [31:0] a, b;
    logic [47:0] r;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0:       r = {a[15:0], b};
      1:       r = {{16{b[31]}}, b};
      2:       r = {{24{b[23]}}, b[23:0]};
      default: r = a[0] ? 48'h0000_7FFF_FF00 : 48'hFFFF_8000_0000;
    endcase
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [47:0] sat_sum [4];
    logic [4:0]  sat_sh  [4];
    logic        sat_rl  [4];
    logic [23:0] sat_exp [4];
    int          n_wr, n_done;
    logic [15:0] last_addr;
    logic        chk_next;

    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_postshift = '0;
    bus.in_oloc = '0; bus.in_last = 1'b0; bus.wr_gnt = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_wr_req",  64'(bus.wr_req),  64'(0));
    check_eq("rst_wr_en",   64'(bus.wr_en),   64'(0));
    check_eq("rst_wr_bus",  64'({bus.wr_addr, bus.wr_data}), 64'(0));
    check_eq("rst_nw",      64'(nw),   64'(0));
    check_eq("rst_done",    64'(done), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Basic path and accept-to-write latency
    send1(48'h0000_0012_3400, 5'd8, 16'h0040, 1'b0, 1'b0);
    check_eq("lat_c1_req", 64'(bus.wr_req), 64'(0));
    check_eq("lat_c1_en",  64'(bus.wr_en),  64'(0));
    @(negedge clk);
    check_eq("lat_c2_req", 64'(bus.wr_req), 64'(1));
    check_eq("lat_c2_en",  64'(bus.wr_en),  64'(0));
    @(negedge clk);
    check_eq("lat_c3_en",   64'(bus.wr_en),   64'(1));
    check_eq("lat_c3_addr", 64'(bus.wr_addr), 64'(16'h0040));
    check_eq("lat_c3_data", 64'(bus.wr_data), 64'(24'h001234));
    @(negedge clk);

    // Saturation and ReLU corners
    sat_sum = '{48'h0000_8000_0000, 48'hFF00_0000_0000, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB};
    sat_sh  = '{5'd4, 5'd0, 5'd1, 5'd1};
    sat_rl  = '{1'b0, 1'b0, 1'b0, 1'b1};
    sat_exp = '{24'h7FFFFF, 24'h800000, 24'hFFFFFD, 24'h000000};
    for (int i = 0; i < 4; i++) begin
      send1(sat_sum[i], sat_sh[i], 16'h0200 + 16'(i), 1'b0, sat_rl[i]);
      wait_write($sformatf("sat%0d", i), 16'h0200 + 16'(i), sat_exp[i]);
    end

    // Backpressure: four accepts fill the fifo, fifth waits for the first pop
    bus.wr_gnt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_in(48'(i + 1) << 8, 5'd8, 16'h0100 + 16'(i), 1'b0, 1'b0);
      if (i < 4) @(negedge clk);
    end
    check_eq("bp_full", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    check_eq("bp_hold", 64'(bus.in_ready), 64'(0));
    bus.wr_gnt = 1'b1;
    @(negedge clk);
    check_eq("bp_first_en",   64'(bus.wr_en),   64'(1));
    check_eq("bp_first_addr", 64'(bus.wr_addr), 64'(16'h0100));
    check_eq("bp_no_bypass",  64'(bus.in_ready), 64'(0));
    n_wr = 1;
    @(negedge clk);
    check_eq("bp_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wr_en) begin
        n_wr++;
        last_addr = bus.wr_addr;
      end
      @(negedge clk);
    end
    check_eq("bp_writes", 64'(n_wr), 64'(5));
    check_eq("bp_fifth",  64'(last_addr), 64'(16'h0104));

    // Grant delay: request held, exactly one write after grant
    bus.wr_gnt = 1'b0;
    send1(48'h0000_0000_0700, 5'd8, 16'h0300, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (bus.wr_req) break;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check_eq("gd_req_hold", 64'(bus.wr_req), 64'(1));
      check_eq("gd_no_en",    64'(bus.wr_en),  64'(0));
      @(negedge clk);
    end
    bus.wr_gnt = 1'b1;
    @(negedge clk);
    check_eq("gd_en",   64'(bus.wr_en),   64'(1));
    check_eq("gd_data", 64'(bus.wr_data), 64'(24'h000007));
    @(negedge clk);
    check_eq("gd_once", 64'(bus.wr_en),   64'(0));

    // Completion: counter restart, done after the last-flagged write
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("clr_nw", 64'(nw), 64'(0));
    n_wr = 0; n_done = 0; chk_next = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (chk_next) begin
        check_eq("cmp_done", 64'(done), 64'(1));
        check_eq("cmp_nw",   64'(nw),   64'(3));
        chk_next = 1'b0;
      end
      if (done) n_done++;
      if (bus.wr_en) begin
        n_wr++;
        if (n_wr == 3) chk_next = 1'b1;
      end
      if (i < 3) set_in(48'(i + 10), 5'd0, 16'h0400 + 16'(i), i == 2, 1'b0);
      else bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("cmp_writes",    64'(n_wr),   64'(3));
    check_eq("cmp_done_once", 64'(n_done), 64'(1));

    // Reset and clear with entries pending
    for (int pass = 0; pass < 2; pass++) begin
      bus.wr_gnt = 1'b0;
      @(negedge clk);
      set_in(48'h0000_0000_0055, 5'd0, 16'h0500, 1'b0, 1'b0);
      @(negedge clk);
      set_in(48'h0000_0000_0066, 5'd0, 16'h0501, 1'b1, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      if (pass == 0) reset = 1'b0;
      else clear = 1'b1;
      @(negedge clk);
      check_eq($sformatf("abort%0d_wr_req", pass), 64'(bus.wr_req), 64'(0));
      check_eq($sformatf("abort%0d_wr_en",  pass), 64'(bus.wr_en),  64'(0));
      check_eq($sformatf("abort%0d_wr_bus", pass), 64'({bus.wr_addr, bus.wr_data}), 64'(0));
      check_eq($sformatf("abort%0d_nw",     pass), 64'(nw),   64'(0));
      check_eq($sformatf("abort%0d_done",   pass), 64'(done), 64'(0));
      reset = 1'b1;
      clear = 1'b0;
      bus.wr_gnt = 1'b1;
      n_wr = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus.wr_en) n_wr++;
      end
      check_eq($sformatf("abort%0d_no_wr",   pass), 64'(n_wr), 64'(0));
      check_eq($sformatf("abort%0d_nw_post", pass), 64'(nw),   64'(0));
    end

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      bus.wr_gnt = ($urandom_range(0, 3) != 0);
      clear      = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0)
        set_in(rand_sum(), 5'($urandom_range(0, 31)), 16'($urandom),
               ($urandom_range(0, 5) == 0), 1'($urandom));
      else
        bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear = 1'b0;
    bus.wr_gnt = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("drain_empty", 64'(mq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_writeback.md
NEURON_WRITEBACK -- requirements
Module: neuron_writeback

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the result FIFO entry count (power of two, at least 2).
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  calculator result present.
REQ-005 in_ready  out  1  block can accept a result.
REQ-006 in_sum  in  48  signed accumulated neuron sum.
REQ-007 in_postshift  in  5  right-shift amount, 0..31.
REQ-008 in_oloc  in  16  data-memory destination address.
REQ-009 in_last  in  1  result is the final neuron of the run.
REQ-010 relu_en  in  1  clamp negative results to 0.
REQ-011 clear  in  1  synchronous flush.
REQ-012 wr_req  out  1  data-memory port request to the arbiter.
REQ-013 wr_gnt  in  1  arbiter grant.
REQ-014 wr_en  out  1  data-memory write strobe.
REQ-015 wr_addr  out  16  write address.
REQ-016 wr_data  out  24  signed write data.
REQ-017 neurons_written  out  11  count of completed writes.
REQ-018 done  out  1  one-cycle pulse after the last-flagged write.

Function
REQ-019 Accept SHALL occur on any rising edge where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal not-full of the FIFO, with no same-cycle pop bypass.
REQ-021 Each accepted result SHALL be stored as {in_oloc, in_last, sat24(ReLU(in_sum >>> in_postshift))}.
- >>> is an arithmetic shift that floors toward minus infinity.
REQ-022 sat24 SHALL map values above 0x7FFFFF to 0x7FFFFF and values below -0x800000 to 0x800000. All other values SHALL pass through as the low 24 bits.
REQ-023 When relu_en is 1, ReLU SHALL replace negative shifted values with 0 before saturation. When relu_en is 0, it SHALL pass values unchanged.
REQ-024 The write FSM SHALL have three states: IDLE, REQ and WRITE.
- IDLE -> REQ when the FIFO is non-empty.
- REQ holds wr_req=1 until wr_gnt=1, then moves to WRITE.
- WRITE drives wr_en=1 for exactly one cycle with the head entry on wr_addr and wr_data, and pops the head.
- WRITE -> REQ if the FIFO still holds data after the pop, otherwise WRITE -> IDLE.
REQ-025 A result accepted at edge N SHALL appear at the FIFO head at N+1. wr_req SHALL be asserted no earlier than the cycle after edge N. Minimum accept-to-wr_en latency SHALL be 2 cycles with wr_gnt tied high.
REQ-026 wr_addr and wr_data SHALL be 0 whenever wr_en is 0.
REQ-027 A simultaneous push and pop SHALL leave the occupancy unchanged. Push while full SHALL be impossible because in_ready=0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 neurons_written SHALL increment on every wr_en and wrap from 2047 to 0.
REQ-030 done SHALL pulse for one cycle, on the cycle after the wr_en of an entry whose last flag is set.
REQ-031 clear SHALL take effect on the next edge:
- FIFO emptied, FSM to IDLE, neurons_written reset to 0, done deasserted;
- clear overrides any accept or pop in the same cycle.

Reset
REQ-032 While reset is 0, the following SHALL be held at 0:
- FIFO pointers and occupancy;
- FSM state (IDLE);
- neurons_written, done, wr_req, wr_en, wr_addr and wr_data.
in_ready SHALL be 1 as soon as reset deasserts.
REQ-033 Reset asserted mid-transfer SHALL abandon pending entries. No wr_en SHALL be produced for them after release.

Structure
REQ-034 The shared nn package SHALL hold:
- the calculator-result struct (Sum, PostShift, Oloc, last);
- the 24-bit saturation limits;
- the writeback FSM state enum.
REQ-035 The FIFO SHALL be one sub-module, wb_fifo, parameterised by DEPTH and entry width. Shift/saturate logic and the FSM SHALL stay in neuron_writeback.

Verification
REQ-036 Basic path: sum=0x000000123400, shift=8, oloc=0x0040, wr_gnt=1 -> wr_en with wr_addr=0x0040 and wr_data=0x001234, two cycles after accept.
REQ-037 Saturation and ReLU:
- sum=0x000080000000, shift=4 -> 0x7FFFFF;
- sum=0xFF0000000000, shift=0 -> 0x800000;
- sum=-5, shift=1, relu_en=0 -> 0xFFFFFD;
- sum=-5, shift=1, relu_en=1 -> 0x000000.
REQ-038 Backpressure: wr_gnt=0 and 5 valid results offered -> in_ready falls after the 4th accept. Then raise wr_gnt -> 4 writes in order, and the 5th is accepted on the cycle after the first pop.
REQ-039 Grant delay: wr_gnt held low for 3 cycles in REQ -> wr_req stays 1 and no wr_en occurs. Raise wr_gnt -> exactly one wr_en on the following cycle.
REQ-040 Completion: 3 results with the 3rd flagged last -> neurons_written=3, and done pulses once on the cycle after the 3rd wr_en.
REQ-041 Reset and clear mid-operation:
- reset low with 2 entries queued -> all outputs 0; after release, no wr_en and neurons_written=0;
- repeat using clear -> identical result.
